// File: rtl/unpack8_pkg.sv
// Shared constants and state type for the eight-lane stream unpacker.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package unpack8_pkg;

    localparam int LANES = 8;
    localparam int IDX_W = 3;

    // Index of the final lane of a word.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/unpack8_holdreg.sv
// One-entry valid/ready holding register that parks the next word while the current one drains.
// Latency: 1 cycle from push to out_vld; only built when UNPACK8_STREAM_WN_PREFETCH_EN is defined.
// Backpressure: in_rdy is low while the entry is full; the entry stays put until out_rdy pops it.
`ifdef UNPACK8_STREAM_WN_PREFETCH_EN
module unpack8_holdreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_dat,
    input  logic         in_vld,
    output logic         in_rdy,
    output logic [W-1:0] out_dat,
    output logic         out_vld,
    input  logic         out_rdy
);

    logic         full_q;
    logic [W-1:0] dat_q;

    assign in_rdy  = !full_q;
    assign out_vld = full_q;
    assign out_dat = dat_q;

    // Fill when empty and offered a word; drain when the consumer takes it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_q <= 1'b0;
            dat_q  <= '0;
        end else if (in_vld && in_rdy) begin
            full_q <= 1'b1;
            dat_q  <= in_dat;
        end else if (out_rdy && full_q) begin
            full_q <= 1'b0;
        end
    end

endmodule
`endif

// File: rtl/unpack8_stream_wn.sv
// Streaming unpacker: one 8-lane word in, lanes out one per transfer, lane 0 first (UNPACK8_STREAM_WN_PREFETCH_EN adds a holding register).
// Latency: word accepted at edge N shows lane 0 in cycle N+1; back-to-back words stream with no bubble.
// Backpressure: out_ready low freezes the presented lane; in_ready opens only when the word can be taken.
module unpack8_stream_wn
    import unpack8_pkg::*;
#(
    parameter int inwidth = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [LANES*inwidth-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [inwidth-1:0]       out_data,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready
);

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         cnt_q, cnt_d;
    logic [LANES*inwidth-1:0] word_q, word_d;
    logic [LANES*inwidth-1:0] new_word;
    logic                     xfer;
    logic                     last_xfer;
    logic                     load_new;
    logic [inwidth-1:0]       lane [LANES];

    // Lane select is a plain mux on the counter; the word register never shifts.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane[k] = word_q[k*inwidth +: inwidth];
    end

    assign out_valid = (state_q == SHIFT);
    assign out_idx   = cnt_q;
    assign out_data  = lane[cnt_q];
    // The counter parks at 7 in IDLE, so last is qualified by valid.
    assign out_last  = out_valid && (cnt_q == LAST_IDX);
    assign xfer      = out_valid && out_ready;
    assign last_xfer = xfer && (cnt_q == LAST_IDX);

`ifdef UNPACK8_STREAM_WN_PREFETCH_EN
    logic                     direct;
    logic                     hold_in_vld;
    logic                     hold_in_rdy;
    logic [LANES*inwidth-1:0] hold_dat;
    logic                     hold_vld;

    // A word goes straight to the word register when nothing would otherwise
    // occupy it next cycle; this keeps the holding register empty in IDLE.
    assign direct      = (state_q == IDLE) || (last_xfer && !hold_vld);
    assign hold_in_vld = in_valid && !direct;
    assign in_ready    = !reset && hold_in_rdy;
    assign load_new    = (direct && in_valid && in_ready) || (last_xfer && hold_vld);
    assign new_word    = (last_xfer && hold_vld) ? hold_dat : in_data;

    unpack8_holdreg #(
        .W(LANES*inwidth)
    ) u_holdreg (
        .clk     (clk),
        .reset   (reset),
        .in_dat  (in_data),
        .in_vld  (hold_in_vld),
        .in_rdy  (hold_in_rdy),
        .out_dat (hold_dat),
        .out_vld (hold_vld),
        .out_rdy (last_xfer)
    );
`else
    // Take a new word only when idle or when lane 7 leaves this very cycle.
    assign in_ready = !reset && ((state_q == IDLE) || last_xfer);
    assign load_new = in_valid && in_ready;
    assign new_word = in_data;
`endif

    // Next-state: load a word, advance the lane, or fall back to IDLE after lane 7.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        case (state_q)
            IDLE: begin
                if (load_new) begin
                    word_d  = new_word;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (xfer) begin
                    if (cnt_q != LAST_IDX) begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end else if (load_new) begin
                        word_d = new_word;
                        cnt_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, lane counter and word register; reset discards any held word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
        end
    end

endmodule

// File: tb/tb_unpack8_stream_wn.sv
// Self-checking bench for unpack8_stream_wn (inwidth=4 main instance, inwidth=1 serial instance).
// Latency: n/a (testbench).
// Backpressure: randomized out_ready and in_valid against a lane-queue reference model.
module tb_unpack8_stream_wn;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  out_data;
    logic [2:0]  out_idx;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    logic [7:0]  b_in_data;
    logic        b_in_valid;
    logic        b_in_ready;
    logic [0:0]  b_out_data;
    logic [2:0]  b_out_idx;
    logic        b_out_last;
    logic        b_out_valid;
    logic        b_out_ready;

    unpack8_stream_wn #(.inwidth(4)) u_dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    unpack8_stream_wn #(.inwidth(1)) u_dut_b (
        .clk(clk), .reset(reset), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_idx(b_out_idx), .out_last(b_out_last), .out_valid(b_out_valid),
        .out_ready(b_out_ready)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: every accepted word becomes eight pending lanes, lane 0 first.
    int q_dat[$];
    int q_idx[$];

    logic        last_acc   = 1'b0;
    int          n_xfer     = 0;
    logic        stall_prev = 1'b0;
    logic [3:0]  prev_data;
    logic [2:0]  prev_idx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One clock: check outputs at the falling edge, then update the model at the rising edge.
    task automatic cycle();
        logic exp_rdy;
        logic acc;
        logic xf;
        logic [31:0] word;
        @(negedge clk);
        check("out_valid", 32'(out_valid), 32'(q_dat.size() != 0));
        if (q_dat.size() != 0) begin
            check("out_data", 32'(out_data), 32'(q_dat[0]));
            check("out_idx",  32'(out_idx),  32'(q_idx[0]));
            check("out_last", 32'(out_last), 32'(q_idx[0] == 7));
        end
`ifdef UNPACK8_STREAM_WN_PREFETCH_EN
        exp_rdy = (q_dat.size() <= 8);
`else
        exp_rdy = (q_dat.size() == 0) || (q_dat.size() == 1 && out_ready);
`endif
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (stall_prev) begin
            check("stall_data", 32'(out_data), 32'(prev_data));
            check("stall_idx",  32'(out_idx),  32'(prev_idx));
        end
        acc        = in_valid && in_ready;
        xf         = out_valid && out_ready;
        stall_prev = out_valid && !out_ready;
        prev_data  = out_data;
        prev_idx   = out_idx;
        word       = in_data;
        @(posedge clk);
        if (xf && q_dat.size() != 0) begin
            void'(q_dat.pop_front());
            void'(q_idx.pop_front());
            n_xfer++;
        end
        if (acc) begin
            for (int k = 0; k < 8; k++) begin
                q_dat.push_back(int'((word >> (4 * k)) & 32'hF));
                q_idx.push_back(k);
            end
        end
        last_acc = acc;
        #1;
    endtask

    task automatic wait_accept(input int budget);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!last_acc && n < budget);
        check("accept_seen", 32'(last_acc), 32'd1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q_dat.size() != 0 && n < budget) begin
            cycle();
            n++;
        end
        cycle();
        check("drained", 32'(q_dat.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          x0;
        logic [0:7]  exp_ser;

        reset       = 1'b1;
        in_data     = '0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        b_in_data   = '0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;

        // Reset state.
        #12;
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_idx",   32'(out_idx),   32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        cycle();

        // Single word, full-rate consumer.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h76543210;
        wait_accept(4);
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        check("single_done", 32'(q_dat.size()), 32'd0);

        // Back-to-back words with in_valid held.
        in_valid = 1'b1;
        in_data  = 32'h76543210;
        wait_accept(4);
        in_data = 32'hFEDCBA98;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!last_acc && n < 20);
`ifdef UNPACK8_STREAM_WN_PREFETCH_EN
        check("b2b_second_accept", 32'(n), 32'd1);
`else
        check("b2b_second_accept", 32'(n), 32'd8);
`endif
        drain(40);

        // Random backpressure and random word arrivals.
        in_valid = 1'b0;
        last_acc = 1'b0;
        for (int i = 0; i < 400; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (!in_valid || last_acc) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = $urandom;
            end
            cycle();
        end
        drain(60);

        // Reset mid-word after lane 3 has transferred.
        in_valid = 1'b1;
        in_data  = 32'h89ABCDEF;
        wait_accept(4);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        check("pre_reset_idx", 32'(out_idx), 32'd4);
        #2 reset = 1'b1;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_in_ready",  32'(in_ready),  32'd0);
        q_dat.delete();
        q_idx.delete();
        stall_prev = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) cycle();

`ifdef UNPACK8_STREAM_WN_PREFETCH_EN
        // Stalled consumer: exactly two words fit, then all 16 lanes drain in order.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = $urandom;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (last_acc) begin
                n++;
                in_data = $urandom;
            end
        end
        check("prefetch_accepts", 32'(n), 32'd2);
        x0 = n_xfer;
        drain(40);
        check("prefetch_lanes", 32'(n_xfer - x0), 32'd16);
`endif

        // Single-bit lanes: serial output of 8'b1010_0110.
        exp_ser     = 8'b0110_0101;
        b_out_ready = 1'b1;
        b_in_data   = 8'b1010_0110;
        b_in_valid  = 1'b1;
        @(negedge clk);
        check("b_in_ready", 32'(b_in_ready), 32'd1);
        @(posedge clk);
        #1 b_in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("b_out_valid", 32'(b_out_valid), 32'd1);
            check("b_out_data",  32'(b_out_data),  32'(exp_ser[i]));
            check("b_out_idx",   32'(b_out_idx),   32'(i));
            check("b_out_last",  32'(b_out_last),  32'(i == 7));
            @(posedge clk);
        end
        @(negedge clk);
        check("b_idle_valid", 32'(b_out_valid), 32'd0);
        check("b_idle_ready", 32'(b_in_ready),  32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
